uart_prog_loader: RTL
=====================

# uart_prog_loader

Serial program loader for the bfloat16 FPU user project. It receives the program image as 8N1 UART bytes on the dedicated serial input pin (mprj_io[5]). It packs every four bytes little-endian into a 32-bit word and writes the word into the core's instruction memory. Once the image is complete, it raises the ready flag that drives mprj_io[37] and releases the FPU core from reset. It sits directly upstream of the FPU core and its instruction memory.

## Interface
Parameters:
- CLKS_PER_BIT, 347, clock cycles per UART bit (40 MHz / 115200 baud); must be ≥ 4.
- ADDR_W, 8, instruction-memory word-address width.
- END_WORD, 32'h0000_0FFF, terminator word that marks the end of the image; it is never written to memory.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- rx_i  in  1  UART serial input, idles high.
- imem_we_o  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr_o  out  ADDR_W  word address of the write.
- imem_wdata_o  out  32  write data.
- prog_done_o  out  1  image loaded; drives mprj_io[37]; sticky until reset.
- core_rst_o  out  1  FPU core reset; equals ~prog_done_o.
- frame_err_o  out  1  sticky; set on any stop-bit error.

## Operation
- Reset values:
  - imem_we_o=0, imem_addr_o=0, imem_wdata_o=0.
  - prog_done_o=0, core_rst_o=1, frame_err_o=0.
  - Both synchronizer flops=1.
  - RX FSM=IDLE, byte counter=0, bit counter=0.
- rx_i passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- RX FSM states:
  - IDLE: when rxs=0, clear the baud counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs.
    - rxs=0: go to DATA.
    - rxs=1: glitch; return to IDLE with no effect.
  - DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register. Go to STOP after the 8th sample.
  - STOP: sample rxs after CLKS_PER_BIT cycles.
    - rxs=1: pulse byte_valid for one cycle, go to IDLE.
    - rxs=0: set frame_err_o, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1, then go to IDLE.
- Word assembly:
  - Byte k (k=0..3) goes to bits [8k+7:8k]; the first byte received is bits [7:0].
  - The byte counter advances only on byte_valid; a discarded byte does not advance it.
  - On the 4th byte the assembled word is complete:
    - If the word equals END_WORD: set prog_done_o; no write.
    - Otherwise: issue a one-cycle write at the current imem_addr_o, then increment the address.
- Memory full: when the write to address 2^ADDR_W−1 completes, set prog_done_o. The address does not wrap.
- After prog_done_o=1, all RX activity is ignored:
  - FSM held in IDLE.
  - No writes, no frame_err updates.
- A reset at any point aborts the frame, discards any partial word and returns all state to reset values.

## Timing
- rx_i falling edge → START entry: 2–3 cycles (synchronizer).
- Sample points are measured from START entry:
  - Data bit i is sampled at CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT cycles.
  - The stop bit is sampled at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- byte_valid fires the cycle after the stop-bit sample.
- For the 4th byte:
  - imem_we_o is high exactly the cycle after byte_valid.
  - imem_addr_o and imem_wdata_o are valid in the same cycle.
  - imem_addr_o increments on the following cycle.
- prog_done_o rises the cycle after the terminating byte_valid, or the cycle after the final full-memory write. core_rst_o falls in that same cycle.
- A new start bit is accepted on the cycle after the return to IDLE, so back-to-back frames with a 1-bit stop need no gap.
- Throughput is at most one write per 40·CLKS_PER_BIT cycles.

## Test plan
All scenarios use CLKS_PER_BIT=8 and ADDR_W=8 unless stated.
- Bytes 13,05,00,00 → one imem_we_o pulse, addr 0, data 32'h0000_0513; prog_done_o stays 0.
- Two data words (0x00000513, 0x3C5F4093), then bytes FF,0F,00,00 → writes at addr 0 and 1, then prog_done_o=1 and core_rst_o=0 with no third write. Further bytes cause no write.
- rx_i pulsed low for 3 cycles, less than half a bit → no byte_valid, FSM back in IDLE, frame_err_o=0.
- Byte A5 with the stop bit forced low, followed by a clean word 44,33,22,11 → frame_err_o=1, A5 discarded, write at addr 0 of 32'h1122_3344.
- wb_rst_i asserted for 1 cycle after 2 bytes of a word, then bytes 78,56,34,12 → write at addr 0 of 32'h1234_5678; all outputs at reset values during the reset cycle.
- ADDR_W=2, four data words with no terminator → writes at addr 0..3; prog_done_o rises the cycle after the addr-3 write; a fifth word is ignored.

Source files
------------

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives 8N1 UART bytes, packs them little-endian into
// 32-bit words, writes them to instruction memory and releases the core when done.
module uart_prog_loader #(
   parameter int unsigned CLKS_PER_BIT = 347,
   parameter int unsigned ADDR_W       = 8,
   parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              rx_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              prog_done_o,
   output logic              core_rst_o,
   output logic              frame_err_o
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } rx_state_t;

   rx_state_t        state;
   logic             rx_meta;
   logic             rxs;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             byte_valid;
   logic [1:0]       byte_cnt;
   logic [23:0]      word_q;
   logic [31:0]      word_full;

   // Two-flop synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rxs     <= rx_meta;
      end
   end

   // UART receive FSM; held idle once the image is loaded
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= S_IDLE;
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         byte_valid  <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (prog_done_o) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (!rxs) begin
                     baud_cnt <= '0;
                     state    <= S_START;
                  end
               end
               S_START: begin
                  if (baud_cnt == HALF_LAST) begin
                     baud_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rxs ? S_IDLE : S_DATA;
                  end else begin
                     baud_cnt <= baud_cnt + CNT_W'(1);
                  end
               end
               S_DATA: begin
                  if (baud_cnt == BIT_LAST) begin
                     baud_cnt <= '0;
                     shreg    <= {rxs, shreg[7:1]};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= S_STOP;
                     end
                  end else begin
                     baud_cnt <= baud_cnt + CNT_W'(1);
                  end
               end
               S_STOP: begin
                  if (baud_cnt == BIT_LAST) begin
                     baud_cnt <= '0;
                     if (rxs) begin
                        byte_valid <= 1'b1;
                        state      <= S_IDLE;
                     end else begin
                        frame_err_o <= 1'b1;
                        state       <= S_WAIT_IDLE;
                     end
                  end else begin
                     baud_cnt <= baud_cnt + CNT_W'(1);
                  end
               end
               S_WAIT_IDLE: begin
                  if (rxs) begin
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign word_full = {shreg, word_q};

   // Word assembly, memory write and load-complete tracking
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         byte_cnt     <= '0;
         word_q       <= '0;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_wdata_o <= '0;
         prog_done_o  <= 1'b0;
         core_rst_o   <= 1'b1;
      end else begin
         imem_we_o <= 1'b0;
         if (imem_we_o) begin
            if (imem_addr_o == ADDR_MAX) begin
               prog_done_o <= 1'b1;
               core_rst_o  <= 1'b0;
            end else begin
               imem_addr_o <= imem_addr_o + ADDR_W'(1);
            end
         end
         if (byte_valid && !prog_done_o) begin
            case (byte_cnt)
               2'd0:    word_q[7:0]   <= shreg;
               2'd1:    word_q[15:8]  <= shreg;
               2'd2:    word_q[23:16] <= shreg;
               default: word_q        <= word_q;
            endcase
            if (byte_cnt == 2'd3) begin
               byte_cnt <= '0;
               if (word_full == END_WORD) begin
                  prog_done_o <= 1'b1;
                  core_rst_o  <= 1'b0;
               end else begin
                  imem_we_o    <= 1'b1;
                  imem_wdata_o <= word_full;
               end
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
            end
         end
      end
   end

endmodule
